bakraid_ioctl_loader: RTL and testbench

- Upstream stage of the SDRAM block: converts the ROM download byte stream (IOCTL_*) into SDRAM programming writes (PROG_*).
- Maps each byte to one of four SDRAM banks by address window, computes the bank word address and byte mask, and buffers bytes in a small FIFO while the SDRAM controller is busy.
- Drives DWNLD_BUSY so the game stays held until every byte has been committed.

---
 rtl/bakraid_ioctl_loader.sv | 180 ++++++++++++++++++
 tb/tb_bakraid_ioctl_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bakraid_ioctl_loader.sv
// Turns the ROM download byte stream into SDRAM bank writes through a small byte FIFO.
// Latency: 2 cycles from push to PROG_WE when the FIFO is empty; writes are spaced at least 3 cycles apart.
// Backpressure: PROG_WE is held until PROG_RDY; bytes arriving on a full FIFO are dropped and flagged. Optional: BAKRAID_LOADER_CHECKSUM_EN.

module bakraid_ioctl_loader_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;

  assign rd_vld = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_rdy = !full || rd_rdy;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld && wr_rdy) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_vld && rd_rdy)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module bakraid_ioctl_loader #(
  parameter logic [25:0] BA1_START  = 26'h0200000,
  parameter logic [25:0] BA2_START  = 26'h0400000,
  parameter logic [25:0] BA3_START  = 26'h0800000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DOWNLOADING,
  input  logic [25:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DOUT,
  input  logic        IOCTL_WR,
  output logic [21:0] PROG_ADDR,
  output logic [15:0] PROG_DATA,
  output logic [1:0]  PROG_MASK,
  output logic [1:0]  PROG_BA,
  output logic        PROG_WE,
  input  logic        PROG_RDY,
  output logic        DWNLD_BUSY,
  output logic        OVERFLOW,
  output logic        RANGE_ERR,
  output logic [15:0] CHECKSUM
);
  typedef enum logic [1:0] {IDLE, ISSUE, RECOVER} state_t;

  state_t      state, state_nxt;
  logic        dl_q;
  logic        dl_rise;
  logic        push_vld;
  logic        push_rdy;
  logic        pop_vld;
  logic        pop;
  logic [33:0] pop_dat;
  logic [25:0] pop_addr;
  logic [7:0]  pop_byte;
  logic [25:0] base;
  logic [1:0]  bank;
  logic [25:0] offset;
  logic        bad;

  assign dl_rise  = DOWNLOADING && !dl_q;
  assign push_vld = IOCTL_WR && DOWNLOADING;
  assign pop      = (state == IDLE) && pop_vld;
  assign pop_addr = pop_dat[33:8];
  assign pop_byte = pop_dat[7:0];
  assign PROG_WE  = (state == ISSUE);

  bakraid_ioctl_loader_fifo #(.W(34), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (CLK),
    .reset  (RESET),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat ({IOCTL_ADDR, IOCTL_DOUT}),
    .rd_vld (pop_vld),
    .rd_rdy (pop),
    .rd_dat (pop_dat)
  );

  always_comb begin
    bank = 2'd0;
    base = '0;
    if (pop_addr >= BA3_START) begin
      bank = 2'd3;
      base = BA3_START;
    end else if (pop_addr >= BA2_START) begin
      bank = 2'd2;
      base = BA2_START;
    end else if (pop_addr >= BA1_START) begin
      bank = 2'd1;
      base = BA1_START;
    end
    offset = pop_addr - base;
    // Each bank holds 4M words = 8M bytes; anything beyond is unreachable.
    bad    = |offset[25:23];
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop_vld && !bad) state_nxt = ISSUE;
      ISSUE:   if (PROG_RDY) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PROG_ADDR <= '0;
      PROG_DATA <= '0;
      PROG_MASK <= 2'b11;
      PROG_BA   <= '0;
    end else if (pop && !bad) begin
      PROG_ADDR <= offset[22:1];
      PROG_DATA <= {pop_byte, pop_byte};
      PROG_MASK <= offset[0] ? 2'b10 : 2'b01;
      PROG_BA   <= bank;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dl_q       <= 1'b0;
      DWNLD_BUSY <= 1'b0;
      OVERFLOW   <= 1'b0;
      RANGE_ERR  <= 1'b0;
    end else begin
      dl_q       <= DOWNLOADING;
      DWNLD_BUSY <= DOWNLOADING || pop_vld || (state != IDLE);
      OVERFLOW   <= (OVERFLOW && !dl_rise) || (push_vld && !push_rdy);
      RANGE_ERR  <= (RANGE_ERR && !dl_rise) || (pop && bad);
    end
  end

`ifdef BAKRAID_LOADER_CHECKSUM_EN
  logic [15:0] sum_base;
  assign sum_base = dl_rise ? 16'd0 : CHECKSUM;

  always_ff @(posedge CLK) begin
    if (RESET)
      CHECKSUM <= '0;
    else if (push_vld && push_rdy)
      CHECKSUM <= sum_base + {8'd0, IOCTL_DOUT};
    else
      CHECKSUM <= sum_base;
  end
`else
  assign CHECKSUM = 16'd0;
`endif
endmodule

// File: tb/tb_bakraid_ioctl_loader.sv
// Directed bench for bakraid_ioctl_loader: bank mapping, lane select, overflow, range errors,
// reset mid-write and the running checksum.
module tb_bakraid_ioctl_loader;
  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DOWNLOADING = 1'b0;
  logic [25:0] IOCTL_ADDR = '0;
  logic [7:0]  IOCTL_DOUT = '0;
  logic        IOCTL_WR = 1'b0;
  logic        PROG_RDY = 1'b0;
  logic [21:0] PROG_ADDR;
  logic [15:0] PROG_DATA;
  logic [1:0]  PROG_MASK;
  logic [1:0]  PROG_BA;
  logic        PROG_WE;
  logic        DWNLD_BUSY;
  logic        OVERFLOW;
  logic        RANGE_ERR;
  logic [15:0] CHECKSUM;

  int  checks = 0;
  int  errors = 0;
  bit  auto_rdy = 1'b0;
  int  we_cnt = 0;
  wr_t wq[$];

  bakraid_ioctl_loader dut (
    .CLK(CLK), .RESET(RESET), .DOWNLOADING(DOWNLOADING),
    .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DOUT(IOCTL_DOUT), .IOCTL_WR(IOCTL_WR),
    .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA), .PROG_MASK(PROG_MASK),
    .PROG_BA(PROG_BA), .PROG_WE(PROG_WE), .PROG_RDY(PROG_RDY),
    .DWNLD_BUSY(DWNLD_BUSY), .OVERFLOW(OVERFLOW), .RANGE_ERR(RANGE_ERR),
    .CHECKSUM(CHECKSUM)
  );

  always #5 CLK = ~CLK;

  // Controller model: answers a write one cycle after PROG_WE rises and logs it.
  always @(negedge CLK) begin
    if (auto_rdy && PROG_WE && we_cnt >= 1) begin
      PROG_RDY = 1'b1;
      wq.push_back({PROG_BA, PROG_ADDR, PROG_DATA, PROG_MASK});
    end else begin
      PROG_RDY = 1'b0;
    end
    we_cnt = PROG_WE ? we_cnt + 1 : 0;
  end

  task automatic push(input logic [25:0] a, input logic [7:0] d);
    IOCTL_ADDR = a;
    IOCTL_DOUT = d;
    IOCTL_WR   = 1'b1;
    @(negedge CLK);
    IOCTL_WR   = 1'b0;
  endtask

  task automatic restart_dl();
    DOWNLOADING = 1'b0;
    @(negedge CLK);
    DOWNLOADING = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (PROG_ADDR !== 22'd0) begin errors++; $display("FAIL reset_addr got %h want 0", PROG_ADDR); end
    checks++; if (PROG_DATA !== 16'd0) begin errors++; $display("FAIL reset_data got %h want 0", PROG_DATA); end
    checks++; if (PROG_MASK !== 2'b11) begin errors++; $display("FAIL reset_mask got %b want 11", PROG_MASK); end
    checks++; if (PROG_BA !== 2'd0) begin errors++; $display("FAIL reset_ba got %0d want 0", PROG_BA); end
    checks++; if (PROG_WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", PROG_WE); end
    checks++; if (DWNLD_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", DWNLD_BUSY); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", OVERFLOW); end
    checks++; if (RANGE_ERR !== 1'b0) begin errors++; $display("FAIL reset_rerr got %b want 0", RANGE_ERR); end
    checks++; if (CHECKSUM !== 16'd0) begin errors++; $display("FAIL reset_csum got %h want 0", CHECKSUM); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    wr_t exp [2];
    exp[0] = {2'd0, 22'd0, 16'h1212, 2'b01};
    exp[1] = {2'd0, 22'd0, 16'h3434, 2'b10};
    wq.delete();
    auto_rdy = 1'b1;
    DOWNLOADING = 1'b1;
    push(26'h0000000, 8'h12);
    checks++; if (PROG_WE !== 1'b0) begin errors++; $display("FAIL basic_we_early got %b want 0", PROG_WE); end
    @(negedge CLK);
    checks++; if (PROG_WE !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", PROG_WE); end
    push(26'h0000001, 8'h34);
    for (int k = 0; k < 50 && wq.size() < 2; k++) @(negedge CLK);
    checks++; if (DWNLD_BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy_dl got %b want 1", DWNLD_BUSY); end
    DOWNLOADING = 1'b0;
    for (int k = 0; k < 20 && DWNLD_BUSY !== 1'b0; k++) @(negedge CLK);
    checks++; if (DWNLD_BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", DWNLD_BUSY); end
    checks++; if (wq.size() != 2) begin errors++; $display("FAIL basic_count got %0d want 2", wq.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_write%0d got %h want %h", i, (i < wq.size()) ? wq[i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_bank_map();
    wr_t exp [4];
    exp[0] = {2'd2, 22'h000001, 16'hABAB, 2'b10};
    exp[1] = {2'd1, 22'h0FFFFF, 16'h5C5C, 2'b10};
    exp[2] = {2'd3, 22'h000002, 16'h7777, 2'b01};
    exp[3] = {2'd0, 22'h0FFFFF, 16'h1E1E, 2'b01};
    wq.delete();
    auto_rdy = 1'b1;
    restart_dl();
    push(26'h0400003, 8'hAB);
    push(26'h03FFFFF, 8'h5C);
    push(26'h0800004, 8'h77);
    push(26'h01FFFFE, 8'h1E);
    for (int k = 0; k < 80 && wq.size() < 4; k++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL bank_count got %0d want 4", wq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] !== exp[i]) begin
        errors++;
        $display("FAIL bank_write%0d got %h want %h", i, (i < wq.size()) ? wq[i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    wr_t exp;
    wq.delete();
    auto_rdy = 1'b0;
    restart_dl();
    for (int i = 0; i < 6; i++) push(26'h10 + 26'(i), 8'hA0 + 8'(i));
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", OVERFLOW); end
    checks++; if (PROG_WE !== 1'b1 || PROG_DATA !== 16'hA0A0) begin
      errors++; $display("FAIL ovf_issue got we=%b data=%h want we=1 data=a0a0", PROG_WE, PROG_DATA);
    end
    repeat (3) @(negedge CLK);
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL ovf_held got %0d writes want 0", wq.size()); end
    auto_rdy = 1'b1;
    for (int k = 0; k < 100 && wq.size() < 5; k++) @(negedge CLK);
    repeat (20) @(negedge CLK);
    checks++; if (wq.size() != 5) begin errors++; $display("FAIL ovf_count got %0d want 5", wq.size()); end
    for (int i = 0; i < 5; i++) begin
      exp = {2'd0, 22'((26'h10 + 26'(i)) >> 1), {8'hA0 + 8'(i), 8'hA0 + 8'(i)}, (i % 2 == 1) ? 2'b10 : 2'b01};
      checks++;
      if (i >= wq.size() || wq[i] !== exp) begin
        errors++;
        $display("FAIL ovf_write%0d got %h want %h", i, (i < wq.size()) ? wq[i] : '0, exp);
      end
    end
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", OVERFLOW); end
    restart_dl();
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", OVERFLOW); end
  endtask

  task automatic test_range();
    wr_t exp;
    exp = {2'd0, 22'd1, 16'h4242, 2'b01};
    wq.delete();
    auto_rdy = 1'b1;
    push(26'h1200000, 8'h99);
    repeat (6) @(negedge CLK);
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL range_nowrite got %0d writes want 0", wq.size()); end
    checks++; if (RANGE_ERR !== 1'b1) begin errors++; $display("FAIL range_flag got %b want 1", RANGE_ERR); end
    push(26'h0000002, 8'h42);
    for (int k = 0; k < 30 && wq.size() < 1; k++) @(negedge CLK);
    checks++;
    if (wq.size() != 1 || wq[0] !== exp) begin
      errors++;
      $display("FAIL range_next got n=%0d w=%h want n=1 w=%h", wq.size(), (wq.size() > 0) ? wq[0] : '0, exp);
    end
    checks++; if (RANGE_ERR !== 1'b1) begin errors++; $display("FAIL range_sticky got %b want 1", RANGE_ERR); end
    restart_dl();
    checks++; if (RANGE_ERR !== 1'b0) begin errors++; $display("FAIL range_clear got %b want 0", RANGE_ERR); end
  endtask

  task automatic test_reset_mid();
    repeat (6) @(negedge CLK);
    wq.delete();
    auto_rdy = 1'b0;
    push(26'h20, 8'h20);
    push(26'h21, 8'h21);
    push(26'h22, 8'h22);
    DOWNLOADING = 1'b0;
    checks++; if (PROG_WE !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", PROG_WE); end
    RESET = 1'b1;
    @(negedge CLK);
    checks++; if (PROG_WE !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b want 0", PROG_WE); end
    checks++; if (DWNLD_BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", DWNLD_BUSY); end
    RESET = 1'b0;
    auto_rdy = 1'b1;
    repeat (10) @(negedge CLK);
    checks++; if (wq.size() != 0 || PROG_WE !== 1'b0 || DWNLD_BUSY !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got n=%0d we=%b busy=%b want 0 0 0", wq.size(), PROG_WE, DWNLD_BUSY);
    end
  endtask

  task automatic test_checksum();
    logic [15:0] exp_sum;
`ifdef BAKRAID_LOADER_CHECKSUM_EN
    exp_sum = 16'((257 * 255) % 65536);
`else
    exp_sum = 16'd0;
`endif
    wq.delete();
    auto_rdy = 1'b1;
    DOWNLOADING = 1'b1;
    @(negedge CLK);
    checks++; if (CHECKSUM !== 16'd0) begin errors++; $display("FAIL csum_start got %h want 0", CHECKSUM); end
    for (int i = 0; i < 257; i++) begin
      push(26'h0, 8'hFF);
      repeat (4) @(negedge CLK);
    end
    for (int k = 0; k < 100 && wq.size() < 257; k++) @(negedge CLK);
    checks++; if (CHECKSUM !== exp_sum) begin errors++; $display("FAIL csum_value got %h want %h", CHECKSUM, exp_sum); end
    checks++; if (wq.size() != 257) begin errors++; $display("FAIL csum_count got %0d want 257", wq.size()); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL csum_ovf got %b want 0", OVERFLOW); end
    restart_dl();
    checks++; if (CHECKSUM !== 16'd0) begin errors++; $display("FAIL csum_clear got %h want 0", CHECKSUM); end
    DOWNLOADING = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bank_map();
    test_overflow();
    test_range();
    test_reset_mid();
    test_checksum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
